step_counter: RTL and testbench
===============================

// Module: step_counter
// PURPOSE
//   Sequential source stage that drives the parameterized step-incrementer datapath.
//   On start, emits start_val, start_val+STEP, start_val+2*STEP, ... up to LIMIT.
//   Each value is one beat on a valid/ready stream.
//   Sits directly upstream of the incrementer consumers and replaces free-running testbench stimulus.
// PARAMETERS
//   WIDTH  8    data width of start_val/out_data
//   STEP   1    increment per accepted beat; 1 <= STEP <= LIMIT
//   LIMIT  255  inclusive upper bound of the sequence; LIMIT <= 2**WIDTH-1
//   CNT_W  16   width of beat_cnt
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   start      in   1      begin sequence; honoured only in IDLE
//   start_val  in   WIDTH  first value; sampled with start
//   stop       in   1      end sequence after the next accepted beat
//   out_valid  out  1      out_data holds a beat
//   out_ready  in   1      consumer accepts beat
//   out_data   out  WIDTH  current value
//   out_last   out  1      final beat of the sequence (or of the pass, when wrapping)
//   busy       out  1      state != IDLE
//   beat_cnt   out  CNT_W  beats accepted since last start; saturates at all-ones
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; cur=0; base=0; out_valid=0; out_last=0; busy=0;
//     beat_cnt=0; stop_pend=0. Takes effect mid-sequence without waiting for a beat.
//   States: IDLE=2'd0, RUN=2'd1.
//   IDLE: out_valid=0.
//     start=1 -> cur<=start_val, base<=start_val, beat_cnt<=0, RUN.
//     First out_valid appears the cycle after start (latency 1).
//   RUN: out_valid=1; out_data=cur; beat = out_valid & out_ready.
//     start is ignored.
//   Stability: out_data/out_last stay constant while out_valid & !out_ready.
//     out_valid never drops without a beat, except under reset.
//   Arithmetic: sum = {1'b0,cur} + STEP, computed in WIDTH+1 bits.
//     ovf = (sum > LIMIT).
//     out_last is registered: loaded as ovf of the value being loaded into cur.
//     Hence start_val > LIMIT or start_val+STEP > LIMIT gives a single beat with out_last=1.
//   On beat, no stop (stop=0 and stop_pend=0):
//     !ovf -> cur<=sum; stay RUN.
//     ovf -> IDLE (see CONFIGURATION for wrap variant).
//   Stop: stop=1 in RUN sets stop_pend.
//     The next beat (including a beat in the same cycle as stop) -> IDLE; stop_pend<=0.
//     out_last is NOT forced by stop. stop in IDLE is ignored.
//   beat_cnt += 1 on every beat; holds at 2**CNT_W-1.
//   Simultaneous final beat + start: start is ignored (FSM still RUN that cycle).
//   busy = (state==RUN), registered.
// CONFIGURATION
//   Macro STEP_COUNTER_WRAP_EN.
//   Undefined (default): the ovf beat ends the sequence -> IDLE.
//   Defined: the ovf beat reloads cur<=base and stays RUN.
//     out_last pulses on the final beat of each pass.
//     Only stop (or reset) returns to IDLE.
//     beat_cnt keeps counting across passes.
// STRUCTURE
//   Package step_counter_pkg: state typedef/encodings (IDLE, RUN).
//   Sub-module step_add #(WIDTH,STEP): combinational in+STEP producing WIDTH+1-bit sum.
//     This is the same arithmetic as the downstream incrementer.
//   Top holds FSM, cur/base/out_last/stop_pend/beat_cnt registers.
// TESTING
//   1 Basic: WIDTH=8, STEP=3, LIMIT=20, start_val=5, ready=1
//     -> out_data 5,8,11,14,17,20.
//     out_last only on 20; 6 beats; IDLE after; beat_cnt=6.
//   2 Backpressure: same config, ready toggles 1,0,0,1,...
//     -> no value dropped or duplicated.
//     out_data/out_last stable during stalls.
//   3 Edge start: start_val=19, STEP=3, LIMIT=20 -> single beat 19 with out_last=1.
//     start_val=250 with LIMIT=20 -> single beat 250 with out_last=1.
//   4 Stop: stop pulsed while ready=0 at value 11
//     -> 11 is accepted when ready rises, then IDLE; out_last=0 on that beat.
//     start during RUN is ignored.
//   5 Wrap (STEP_COUNTER_WRAP_EN defined): start_val=5, STEP=3, LIMIT=20
//     -> 5..20,5..20; out_last on each 20.
//     stop -> IDLE; beat_cnt=CNT_W-saturating total.
//   6 Reset: assert rst_n=0 mid-RUN at value 14
//     -> out_valid, busy, beat_cnt, out_last 0 immediately.
//     After release, start_val=0 restarts at 0.

Source files
------------

// File: rtl/step_counter_pkg.sv
// Shared state encoding for the step_counter source stage.
package step_counter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
   } state_e;

endpackage

// File: rtl/step_counter_add.sv
// step_add: combinational in + STEP, widened by one bit to expose overflow.
module step_add #(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] in_val,
   output logic [WIDTH:0]   sum
);

   assign sum = {1'b0, in_val} + (WIDTH+1)'(STEP);

endmodule

// File: rtl/step_counter.sv
// step_counter: emits start_val, +STEP, ... up to LIMIT on a valid/ready stream.
// Define STEP_COUNTER_WRAP_EN to restart from start_val after each pass.
module step_counter
   import step_counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1,
   parameter int LIMIT = 255,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] start_val,
   input  logic             stop,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic [CNT_W-1:0] beat_cnt
);

   localparam logic [WIDTH:0]   LIM1 = (WIDTH+1)'(LIMIT);
   localparam logic [WIDTH+1:0] LIM2 = (WIDTH+2)'(LIMIT);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cur_q, cur_d;
   logic             last_q, last_d;
   logic             stop_pend_q, stop_pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH:0]   sum_cur;
   logic [WIDTH:0]   sum_start;
   logic [WIDTH+1:0] sum_next;
   logic             ovf_cur;
   logic             ovf_start;
   logic             ovf_next;
   logic             beat;

   step_add #(.WIDTH(WIDTH), .STEP(STEP)) u_add_cur (
      .in_val (cur_q),
      .sum    (sum_cur)
   );

   step_add #(.WIDTH(WIDTH), .STEP(STEP)) u_add_start (
      .in_val (start_val),
      .sum    (sum_start)
   );

   // Look one step ahead so out_last is ready with the value it tags.
   step_add #(.WIDTH(WIDTH+1), .STEP(STEP)) u_add_next (
      .in_val (sum_cur),
      .sum    (sum_next)
   );

   assign ovf_cur   = sum_cur > LIM1;
   assign ovf_start = sum_start > LIM1;
   assign ovf_next  = sum_next > LIM2;

   assign out_valid = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign out_data  = cur_q;
   assign out_last  = last_q;
   assign beat_cnt  = cnt_q;
   assign beat      = out_valid & out_ready;

`ifdef STEP_COUNTER_WRAP_EN
   logic [WIDTH-1:0] base_q, base_d;
   logic             base_last_q, base_last_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q      <= '0;
         base_last_q <= 1'b0;
      end else begin
         base_q      <= base_d;
         base_last_q <= base_last_d;
      end
   end

   always_comb begin
      base_d      = base_q;
      base_last_d = base_last_q;
      if (state_q == IDLE && start) begin
         base_d      = start_val;
         base_last_d = ovf_start;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      last_d      = last_q;
      stop_pend_d = stop_pend_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               cur_d       = start_val;
               last_d      = ovf_start;
               cnt_d       = '0;
               stop_pend_d = 1'b0;
               state_d     = RUN;
            end
         end
         RUN: begin
            if (beat) begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
               if (stop || stop_pend_q) begin
                  state_d     = IDLE;
                  stop_pend_d = 1'b0;
                  last_d      = 1'b0;
               end else if (!ovf_cur) begin
                  cur_d  = sum_cur[WIDTH-1:0];
                  last_d = ovf_next;
               end else begin
`ifdef STEP_COUNTER_WRAP_EN
                  cur_d  = base_q;
                  last_d = base_last_q;
`else
                  state_d = IDLE;
                  last_d  = 1'b0;
`endif
               end
            end else if (stop) begin
               stop_pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cur_q       <= '0;
         last_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         last_q      <= last_d;
         stop_pend_q <= stop_pend_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_step_counter.sv
// Scoreboard bench for step_counter: model queues expected beats, monitor checks.
module tb_step_counter;

   localparam int W     = 8;
   localparam int STEP  = 3;
   localparam int LIMIT = 20;
   localparam int CW    = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  start_val = '0;
   logic          stop = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic          busy;
   logic [CW-1:0] beat_cnt;

   typedef struct {
      int data;
      bit last;
   } beat_t;

   beat_t q[$];
   int    n_pass = 0;
   int    n_chk = 0;
   int    pops = 0;
   bit    stop_armed = 1'b0;
   bit    prev_stall = 1'b0;
   int    prev_data = 0;
   int    prev_last = 0;

   step_counter #(
      .WIDTH (W),
      .STEP  (STEP),
      .LIMIT (LIMIT),
      .CNT_W (CW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .start_val (start_val),
      .stop      (stop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .beat_cnt  (beat_cnt)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input longint act,
                                 input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endfunction

   // Reference: arithmetic progression from v, last where the next step exceeds LIMIT.
   function automatic int push_seq(input int v);
      int x;
      bit l;
      int passes = 1;
`ifdef STEP_COUNTER_WRAP_EN
      passes = 2;
`endif
      for (int p = 0; p < passes; p++) begin
         x = v;
         do begin
            l = (x + STEP > LIMIT);
            q.push_back('{x, l});
            x += STEP;
         end while (!l);
      end
      return q.size();
   endfunction

   always @(negedge clk) begin
      beat_t e;
      if (rst_n) begin
         if (prev_stall) begin
            check("stable_data", out_data, prev_data);
            check("stable_last", out_last, prev_last);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_beat: got data %0d, required no beat",
                        out_data);
            end else begin
               e = q.pop_front();
               check("data", out_data, e.data);
               check("last", out_last, e.last);
               pops++;
            end
            if (stop || stop_armed) begin
               q.delete();
               stop_armed = 1'b0;
            end
         end else if (out_valid && stop) begin
            stop_armed = 1'b1;
         end
      end else begin
         prev_stall = 1'b0;
         stop_armed = 1'b0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // mode: 0 ready high, 1 ready 1,0,0 pattern, 2 random ready
   task automatic run_seq(input int v, input int mode, input int stop_after,
                          input bit same);
      int len;
      int exp_cnt;
      int k = 0;
      int sp = 0;
      int sa = stop_after;
      q.delete();
      pops = 0;
      len = push_seq(v);
`ifdef STEP_COUNTER_WRAP_EN
      if (sa < 0) sa = len - 1;
`endif
      exp_cnt = (sa >= 0 && sa + 1 < len) ? sa + 1 : len;
      start = 1'b1;
      start_val = W'(v);
      cyc();
      while ((q.size() > 0 || busy) && k < 300) begin
         unique case (mode)
            0: out_ready = 1'b1;
            1: out_ready = (k % 3 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         stop = 1'b0;
         start = ($urandom_range(0, 3) == 0);
         start_val = W'($urandom_range(0, 255));
         if (sa >= 0 && pops == sa && sp < 2) begin
            if (sp == 0) begin
               stop = 1'b1;
               out_ready = same;
            end else begin
               out_ready = 1'b0;
            end
            sp++;
         end
         cyc();
         k++;
      end
      start = 1'b0;
      stop = 1'b0;
      out_ready = 1'b0;
      check("seq_in_time", k < 300, 1);
      check("busy_after", busy, 0);
      check("valid_after", out_valid, 0);
      check("beat_cnt", beat_cnt, exp_cnt);
      cyc();
   endtask

   initial begin
      int v;
      int k;
      #12;
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", beat_cnt, 0);
      check("rst_last", out_last, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      run_seq(5, 0, -1, 1'b0);
      run_seq(5, 1, -1, 1'b0);
      run_seq(19, 0, -1, 1'b0);
      run_seq(250, 2, -1, 1'b0);
      run_seq(18, 1, -1, 1'b0);
      run_seq(20, 0, -1, 1'b0);
      run_seq(5, 2, 2, 1'b0);
      run_seq(0, 0, 3, 1'b1);

      for (int i = 0; i < 12; i++) begin
         v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255)
                                         : $urandom_range(0, 20);
         run_seq(v, $urandom_range(0, 2),
                 ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 6),
                 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of a sequence while 14 is on the bus.
      q.delete();
      pops = 0;
      void'(push_seq(5));
      start = 1'b1;
      start_val = W'(5);
      cyc();
      start = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (pops < 3 && k < 50) begin
         cyc();
         k++;
      end
      out_ready = 1'b0;
      check("reach_14", pops, 3);
      check("cur_14", out_data, 14);
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_cnt", beat_cnt, 0);
      check("mid_rst_last", out_last, 0);
      cyc();
      rst_n = 1'b1;
      cyc();
      run_seq(0, 0, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
